// File: rtl/switch_pkg.sv
// Shared buffer geometry and the beat record passed between the SRAM
// readers/writers and their output FIFOs.
package switch_pkg;

    localparam int BLOCK_BITS  = 64;
    localparam int BLOCK_BYTES = BLOCK_BITS / 8;
    localparam int ADDR_W      = 8;
    localparam int NUM_BLOCKS  = 256;
    localparam int LEN_W       = 11;
    localparam int BYTES_W     = $clog2(BLOCK_BYTES + 1);

    typedef struct packed {
        logic [BLOCK_BITS-1:0] data;
        logic                  last;
        logic [BYTES_W-1:0]    bytes;
        logic [ADDR_W-1:0]     addr;
    } out_beat_t;

endpackage

// File: rtl/beat_fifo.sv
// Three-entry synchronous FIFO of output beats. Storage is cleared on reset
// so an empty FIFO presents an all-zero head.
module beat_fifo (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  switch_pkg::out_beat_t push_beat,
    input  logic                  pop,
    output switch_pkg::out_beat_t head,
    output logic [1:0]            count
);
    import switch_pkg::*;

    out_beat_t  mem [3];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Storage, circular pointers (mod 3) and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/egress_frame_reader.sv
// Egress reader: turns a frame descriptor into one SRAM read per block,
// queues the returned words as tagged beats and frees each block on exit.
//
// state  | meaning
// IDLE   | waiting for a descriptor; FIFO may still be draining
// READ   | issuing block reads while FIFO credits allow
module egress_frame_reader #(
    parameter int BLOCK_BITS = switch_pkg::BLOCK_BITS,
    parameter int ADDR_W     = switch_pkg::ADDR_W,
    parameter int NUM_BLOCKS = switch_pkg::NUM_BLOCKS,
    parameter int LEN_W      = switch_pkg::LEN_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 desc_valid_i,
    output logic                                 desc_ready_o,
    input  logic [ADDR_W-1:0]                    desc_addr_i,
    input  logic [LEN_W-1:0]                     desc_len_i,
    output logic [ADDR_W-1:0]                    r_addr_o,
    input  logic [BLOCK_BITS-1:0]                r_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [BLOCK_BITS-1:0]                out_data_o,
    output logic                                 out_last_o,
    output logic [$clog2(BLOCK_BITS/8+1)-1:0]    out_bytes_o,
    output logic                                 free_valid_o,
    output logic [ADDR_W-1:0]                    free_addr_o
);
    import switch_pkg::*;

    localparam int BEAT_BYTES = BLOCK_BITS / 8;
    localparam int OFS_W      = $clog2(BEAT_BYTES);
    localparam int CNT_W      = $clog2(BEAT_BYTES + 1);

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  blocks_left;
    logic [CNT_W-1:0]  tail_bytes;
    logic              inflight;
    logic              infl_last;
    logic [CNT_W-1:0]  infl_bytes;
    logic [ADDR_W-1:0] infl_addr;

    logic [1:0]        fifo_count;
    out_beat_t         push_beat;
    out_beat_t         head;
    logic              issue;
    logic              pop;

    logic [LEN_W:0]    len_round;
    logic [LEN_W-1:0]  blocks_new;
    logic [OFS_W-1:0]  tail_rem;
    logic [CNT_W-1:0]  tail_new;

    assign len_round  = {1'b0, desc_len_i} + (LEN_W+1)'(BEAT_BYTES - 1);
    assign blocks_new = LEN_W'(len_round >> OFS_W);
    assign tail_rem   = desc_len_i[OFS_W-1:0];
    assign tail_new   = (tail_rem == '0) ? CNT_W'(BEAT_BYTES) : CNT_W'(tail_rem);

    // Credit check counts the word still in the SRAM pipe so a full FIFO
    // can never be overrun by a late push.
    assign issue = (state == S_READ) &&
                   (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd3);

    assign desc_ready_o = (state == S_IDLE);
    assign r_addr_o     = addr_q;

    // Descriptor load, read issue and the one-deep SRAM latency tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            blocks_left <= '0;
            tail_bytes  <= '0;
            inflight    <= 1'b0;
            infl_last   <= 1'b0;
            infl_bytes  <= '0;
            infl_addr   <= '0;
        end else begin
            inflight <= issue;
            case (state)
                S_IDLE: begin
                    if (desc_valid_i) begin
                        addr_q      <= desc_addr_i;
                        blocks_left <= blocks_new;
                        tail_bytes  <= tail_new;
                        if (desc_len_i != '0) state <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        infl_addr   <= addr_q;
                        infl_last   <= (blocks_left == LEN_W'(1));
                        infl_bytes  <= (blocks_left == LEN_W'(1)) ? tail_bytes
                                                                  : CNT_W'(BEAT_BYTES);
                        addr_q      <= (addr_q == ADDR_W'(NUM_BLOCKS - 1)) ? '0
                                                                          : addr_q + ADDR_W'(1);
                        blocks_left <= blocks_left - LEN_W'(1);
                        if (blocks_left == LEN_W'(1)) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign push_beat = '{data: r_data_i, last: infl_last, bytes: infl_bytes, addr: infl_addr};

    beat_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign out_valid_o = (fifo_count != 2'd0);
    assign out_data_o  = out_valid_o ? head.data  : '0;
    assign out_last_o  = out_valid_o ? head.last  : 1'b0;
    assign out_bytes_o = out_valid_o ? head.bytes : '0;
    assign pop         = out_valid_o && out_ready_i;

    // Return each consumed block to the allocator one cycle after it leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_valid_o <= 1'b0;
            free_addr_o  <= '0;
        end else begin
            free_valid_o <= pop;
            if (pop) free_addr_o <= head.addr;
        end
    end

endmodule

// File: doc/egress_frame_reader.md
# egress_frame_reader

Egress-side reader for the shared packet buffer SRAM. It accepts a frame descriptor (start block address, byte length) from the egress queue. It then issues one SRAM read per block, absorbing the SRAM's one-cycle read latency, and streams the blocks out on a valid/ready interface with last-beat and byte-count tags. As each block leaves, its address is returned to the block allocator. It is the read-side counterpart of the ingress writer that fills the SRAM write port.

## Interface
Parameters (defaults come from `switch_pkg`):
- `BLOCK_BITS`, default `switch_pkg::BLOCK_BITS` (64): SRAM word width. `BLOCK_BITS/8` must be a power of two.
- `ADDR_W`, default `switch_pkg::ADDR_W` (8): block address width.
- `NUM_BLOCKS`, default `switch_pkg::NUM_BLOCKS` (256): buffer depth in blocks; addresses wrap modulo this value.
- `LEN_W`, default `switch_pkg::LEN_W` (11): width of the frame byte-length field.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `desc_valid_i`  in  1  descriptor offered.
- `desc_ready_o`  out  1  descriptor accepted when high together with `desc_valid_i`.
- `desc_addr_i`  in  ADDR_W  first block address of the frame.
- `desc_len_i`  in  LEN_W  frame length in bytes.
- `r_addr_o`  out  ADDR_W  SRAM read address.
- `r_data_i`  in  BLOCK_BITS  SRAM read data; valid 1 cycle after `r_addr_o`.
- `out_valid_o`  out  1  output beat valid.
- `out_ready_i`  in  1  downstream accepts the beat.
- `out_data_o`  out  BLOCK_BITS  block data.
- `out_last_o`  out  1  final beat of the frame.
- `out_bytes_o`  out  $clog2(BLOCK_BITS/8+1)  valid bytes in the beat, counted from byte 0 upward.
- `free_valid_o`  out  1  one-cycle pulse: the block has been consumed.
- `free_addr_o`  out  ADDR_W  address of the consumed block.

## Operation
- FSM states: IDLE and READ.
  - `desc_ready_o` = (state == IDLE).
  - A handshake in IDLE loads the following registers:
    - address ← `desc_addr_i`
    - blocks_left ← ceil(len / BLOCK_BYTES)
    - tail_bytes ← len mod BLOCK_BYTES, or BLOCK_BYTES when the remainder is 0
  - If len = 0, the descriptor is consumed, the state stays IDLE and no beat is produced.
  - If len > 0, the state goes to READ.
- Read issue in READ happens only when occupancy + inflight < 3.
  - occupancy is the current count of the 3-entry output FIFO, before any pop this cycle.
  - On issue: inflight ← 1; address ← (address + 1) mod NUM_BLOCKS; blocks_left ← blocks_left − 1.
  - After the issue with blocks_left == 1, the state returns to IDLE. The next descriptor can therefore be accepted while the FIFO still drains.
- `r_addr_o` always reflects the address register. The SRAM reads every cycle, and stale data is ignored unless inflight was set.
- Cycle after an issue: push {r_data_i, last, bytes, block address} into the FIFO.
  - Beats other than the last: last = 0, bytes = BLOCK_BYTES.
  - Last beat: last = 1, bytes = tail_bytes.
- Output is the FIFO head. A pop occurs on `out_valid_o && out_ready_i`.
- `free_valid_o` is a registered pulse in the cycle after each pop, with `free_addr_o` = the popped block's address. The allocator never back-pressures.
- Output stability: while `out_valid_o` is high and `out_ready_i` is low, all `out_*` signals hold stable.
- Reset mid-frame aborts the frame:
  - FIFO emptied, inflight cleared, state = IDLE.
  - Blocks of the aborted frame are not freed; the allocator is reset by the same `rst_n`.

## Timing
- Reset values: `desc_ready_o`=1, `out_valid_o`=0, `out_last_o`=0, `out_bytes_o`=0, `out_data_o`=0, `free_valid_o`=0, `free_addr_o`=0, `r_addr_o`=0.
- Descriptor accepted at edge T:
  - first read issued in cycle T+1;
  - data pushed at the end of T+2;
  - `out_valid_o` high in T+3.
- Throughput: one beat per cycle with `out_ready_i` held high. Back-to-back frames have one IDLE cycle between them.
- Simultaneous push and pop keep occupancy unchanged. The FIFO never overflows because of the credit rule.
- No combinational path exists from `out_ready_i` to `r_addr_o` or `desc_ready_o`.

## Structure
- `switch_pkg` holds `BLOCK_BITS`, `BLOCK_BYTES`, `ADDR_W`, `NUM_BLOCKS` and `LEN_W`, plus a packed `out_beat_t` {data, last, bytes, addr} shared with the ingress writer.
- One sub-module: `beat_fifo`, a 3-entry synchronous FIFO of `out_beat_t` with count output and asynchronous active-low reset.
- The FSM, credit logic and free pulse live in the top module.

## Test plan
Benches use BLOCK_BITS=64, NUM_BLOCKS=256, with an SRAM model that has 1-cycle read latency.
- Descriptor addr 0x10, len 64, ready high → 8 consecutive beats from blocks 0x10–0x17. First beat at T+3. `out_last_o` only on beat 8, `out_bytes_o`=8 on every beat, and 8 free pulses for 0x10..0x17.
- Descriptor len 13 → 2 beats with bytes 8 then 5; last=1 on the second beat. Len 8 → a single beat with last=1 and bytes=8.
- Wrap: addr 0xFE, len 24 → reads and frees at 0xFE, 0xFF, 0x00.
- Random 50% `out_ready_i`, three back-to-back frames → exact data order, no drop or duplicate, `out_*` stable while stalled, FIFO count ≤ 3.
- Descriptor len 0 → no beats, no free pulse, `desc_ready_o` high again in the next cycle.
- Assert `rst_n` after 3 beats of a 10-block frame → all outputs at reset values asynchronously. After release, a new addr 0x40, len 16 frame streams correctly.
